// File: rtl/score_display_pkg.sv
// Shared types, segment encodings and small helpers for the score display.
package score_disp_pkg;

  localparam int unsigned SCORE_W     = 7;
  localparam int unsigned DIGIT_W     = 4;
  localparam int unsigned SEG_W       = 7;
  localparam int unsigned NUM_SHIFTS  = 7;
  localparam int unsigned SHIFT_CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } conv_state_e;

  typedef enum logic {
    NORMAL = 1'b0,
    FLASH  = 1'b1
  } flash_state_e;

  // Three-digit BCD accumulator used by the shift-add-3 converter.
  typedef struct packed {
    logic [DIGIT_W-1:0] hundreds;
    logic [DIGIT_W-1:0] tens;
    logic [DIGIT_W-1:0] ones;
  } bcd_t;

  // Segment order is {g,f,e,d,c,b,a}, active-high.
  localparam logic [SEG_W-1:0] SEG_0     = 7'b0111111;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b1011011;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b1100110;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b1101101;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b1111101;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b0000111;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b1101111;
  localparam logic [SEG_W-1:0] SEG_DASH  = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

  function automatic logic [SEG_W-1:0] seg_decode(input logic [DIGIT_W-1:0] val);
    logic [SEG_W-1:0] seg;
    case (val)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  // Double-dabble correction applied to one BCD nibble before each shift.
  function automatic logic [DIGIT_W-1:0] add3_adj(input logic [DIGIT_W-1:0] nib);
    return (nib >= 4'd5) ? DIGIT_W'(nib + 4'd3) : nib;
  endfunction

endpackage

// File: rtl/score_display_bin2bcd.sv
// Multi-cycle binary-to-BCD converter: one shift-add-3 step per clock.
module bin2bcd_seq
  import score_disp_pkg::*;
(
  input  logic               clk,
  input  logic               nRst,
  input  logic               start,
  input  logic [SCORE_W-1:0] bin,
  output logic               busy,
  output logic               done,
  output logic [DIGIT_W-1:0] hundreds,
  output logic [DIGIT_W-1:0] tens,
  output logic [DIGIT_W-1:0] ones
);

  conv_state_e            r_state;
  conv_state_e            w_state_nxt;
  logic [SCORE_W-1:0]     r_sr;
  logic [SCORE_W-1:0]     w_sr_nxt;
  bcd_t                   r_bcd;
  bcd_t                   w_bcd_nxt;
  bcd_t                   w_adj;
  logic [SHIFT_CNT_W-1:0] r_cnt;
  logic [SHIFT_CNT_W-1:0] w_cnt_nxt;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_state <= IDLE;
      r_sr    <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sr    <= w_sr_nxt;
      r_bcd   <= w_bcd_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_sr_nxt       = r_sr;
    w_bcd_nxt      = r_bcd;
    w_cnt_nxt      = r_cnt;
    w_adj.hundreds = add3_adj(r_bcd.hundreds);
    w_adj.tens     = add3_adj(r_bcd.tens);
    w_adj.ones     = add3_adj(r_bcd.ones);
    case (r_state)
      IDLE: begin
        if (start) begin
          w_sr_nxt    = bin;
          w_bcd_nxt   = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        // Corrected accumulator and remaining binary bits shift as one word.
        {w_bcd_nxt, w_sr_nxt} = {w_adj, r_sr} << 1;
        w_cnt_nxt = SHIFT_CNT_W'(r_cnt + 1'b1);
        if (r_cnt == SHIFT_CNT_W'(NUM_SHIFTS - 1)) begin
          w_state_nxt = LOAD;
        end
      end
      LOAD: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign busy     = (r_state != IDLE);
  assign done     = (r_state == LOAD);
  assign hundreds = r_bcd.hundreds;
  assign tens     = r_bcd.tens;
  assign ones     = r_bcd.ones;

endmodule

// File: rtl/score_display.sv
// Score reader: converts the tracker score to two seven-segment digits and
// flashes the frozen final score at game end before showing the new value.
module score_display
  import score_disp_pkg::*;
#(
  parameter int unsigned FLASH_HALF    = 6_000_000,
  parameter int unsigned FLASH_PERIODS = 3
) (
  input  logic               clk,
  input  logic               nRst,
  input  logic [SCORE_W-1:0] dispScore,
  input  logic               isGameComplete,
  output logic [SEG_W-1:0]   ss1,
  output logic [SEG_W-1:0]   ss0,
  output logic               flashing
);

  localparam int unsigned HALF_W    = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
  localparam int unsigned PER_W     = $clog2(FLASH_PERIODS + 1);
  localparam int unsigned HALF_LAST = FLASH_HALF - 1;
  localparam int unsigned PER_LAST  = FLASH_PERIODS - 1;

  logic [SCORE_W-1:0] r_last_score;
  logic               r_gc_prev;
  logic [DIGIT_W-1:0] r_hund;
  logic [DIGIT_W-1:0] r_tens;
  logic [DIGIT_W-1:0] r_ones;

  flash_state_e       r_fstate;
  flash_state_e       w_fstate_nxt;
  logic [HALF_W-1:0]  r_half;
  logic [HALF_W-1:0]  w_half_nxt;
  logic [PER_W-1:0]   r_per;
  logic [PER_W-1:0]   w_per_nxt;
  logic               r_blank;
  logic               w_blank_nxt;

  logic               w_gc_rise;
  logic               w_start;
  logic               w_busy;
  logic               w_done;
  logic [DIGIT_W-1:0] w_hund;
  logic [DIGIT_W-1:0] w_tens;
  logic [DIGIT_W-1:0] w_ones;

  assign w_gc_rise = isGameComplete & ~r_gc_prev;

  // Freeze: a flash in progress or starting this edge blocks new conversions.
  assign w_start = ~w_busy & (dispScore != r_last_score) &
                   (r_fstate == NORMAL) & ~w_gc_rise;

  bin2bcd_seq u_bin2bcd (
    .clk      (clk),
    .nRst     (nRst),
    .start    (w_start),
    .bin      (dispScore),
    .busy     (w_busy),
    .done     (w_done),
    .hundreds (w_hund),
    .tens     (w_tens),
    .ones     (w_ones)
  );

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_last_score <= '0;
      r_gc_prev    <= 1'b0;
      r_hund       <= '0;
      r_tens       <= '0;
      r_ones       <= '0;
    end else begin
      r_gc_prev <= isGameComplete;
      if (w_start) begin
        r_last_score <= dispScore;
      end
      if (w_done) begin
        r_hund <= w_hund;
        r_tens <= w_tens;
        r_ones <= w_ones;
      end
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_fstate <= NORMAL;
      r_half   <= '0;
      r_per    <= '0;
      r_blank  <= 1'b0;
    end else begin
      r_fstate <= w_fstate_nxt;
      r_half   <= w_half_nxt;
      r_per    <= w_per_nxt;
      r_blank  <= w_blank_nxt;
    end
  end

  always_comb begin
    w_fstate_nxt = r_fstate;
    w_half_nxt   = r_half;
    w_per_nxt    = r_per;
    w_blank_nxt  = r_blank;
    case (r_fstate)
      NORMAL: begin
        if (w_gc_rise) begin
          w_fstate_nxt = FLASH;
          w_half_nxt   = '0;
          w_per_nxt    = '0;
          w_blank_nxt  = 1'b1;
        end
      end
      FLASH: begin
        if (!isGameComplete) begin
          w_fstate_nxt = NORMAL;
          w_blank_nxt  = 1'b0;
        end else if (r_half == HALF_W'(HALF_LAST)) begin
          w_half_nxt  = '0;
          w_blank_nxt = ~r_blank;
          // End of a lit half closes one blank+lit period.
          if (!r_blank) begin
            w_per_nxt = PER_W'(r_per + 1'b1);
            if (r_per == PER_W'(PER_LAST)) begin
              w_fstate_nxt = NORMAL;
              w_blank_nxt  = 1'b0;
            end
          end
        end else begin
          w_half_nxt = HALF_W'(r_half + 1'b1);
        end
      end
      default: begin
        w_fstate_nxt = NORMAL;
        w_blank_nxt  = 1'b0;
      end
    endcase
  end

  // Segment decode: dashes for 100+, leading-zero suppression on the tens digit.
  always_comb begin
    ss1 = SEG_BLANK;
    ss0 = SEG_BLANK;
    if (!r_blank) begin
      if (r_hund != '0) begin
        ss1 = SEG_DASH;
        ss0 = SEG_DASH;
      end else begin
        ss1 = (r_tens == '0) ? SEG_BLANK : seg_decode(r_tens);
        ss0 = seg_decode(r_ones);
      end
    end
  end

  assign flashing = (r_fstate == FLASH);

endmodule

// File: tb/tb_score_display.sv
// Scoreboard bench for score_display: expectations are queued with the cycle
// at which the display must show them and compared on the falling edge.
module tb_score_display;

  localparam int unsigned FH = 4;
  localparam int unsigned FP = 2;

  logic       clk = 1'b0;
  logic       nRst = 1'b0;
  logic [6:0] dispScore = 7'd0;
  logic       isGameComplete = 1'b0;
  logic [6:0] ss1;
  logic [6:0] ss0;
  logic       flashing;

  always #5 clk = ~clk;

  score_display #(
    .FLASH_HALF    (FH),
    .FLASH_PERIODS (FP)
  ) dut (
    .clk            (clk),
    .nRst           (nRst),
    .dispScore      (dispScore),
    .isGameComplete (isGameComplete),
    .ss1            (ss1),
    .ss0            (ss0),
    .flashing       (flashing)
  );

  typedef struct {
    int         due;
    logic [6:0] s1;
    logic [6:0] s0;
    logic       fl;
  } exp_t;

  exp_t  sb[$];
  string sb_tag[$];
  exp_t  e_chk;
  string t_chk;
  int    cyc = 0;
  int    n_cmp = 0;
  int    n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] seg7(input int d);
    case (d)
      0: return 7'b0111111;
      1: return 7'b0000110;
      2: return 7'b1011011;
      3: return 7'b1001111;
      4: return 7'b1100110;
      5: return 7'b1101101;
      6: return 7'b1111101;
      7: return 7'b0000111;
      8: return 7'b1111111;
      9: return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

  // Expected {ss1, ss0} for a displayed score.
  function automatic logic [13:0] shown(input int v);
    logic [6:0] t;
    if (v >= 100) return {7'b1000000, 7'b1000000};
    t = ((v / 10) == 0) ? 7'b0000000 : seg7(v / 10);
    return {t, seg7(v % 10)};
  endfunction

  task automatic push(input string tag, input int due, input int val,
                      input logic fl, input logic blank);
    exp_t        e;
    logic [13:0] s;
    s     = shown(val);
    e.due = due;
    e.s1  = blank ? 7'd0 : s[13:7];
    e.s0  = blank ? 7'd0 : s[6:0];
    e.fl  = fl;
    sb.push_back(e);
    sb_tag.push_back(tag);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e_chk = sb.pop_front();
      t_chk = sb_tag.pop_front();
      if (e_chk.due != cyc) begin
        check_eq($sformatf("%s.late", t_chk), cyc, e_chk.due);
      end else begin
        check_eq($sformatf("%s.ss1@%0d", t_chk, cyc), int'(ss1), int'(e_chk.s1));
        check_eq($sformatf("%s.ss0@%0d", t_chk, cyc), int'(ss0), int'(e_chk.s0));
        check_eq($sformatf("%s.flashing@%0d", t_chk, cyc), int'(flashing), int'(e_chk.fl));
      end
    end
  end

  initial begin
    int base;
    int cur;
    int vals [7];
    vals = '{9, 105, 10, 99, 100, 127, 0};

    // Reset state
    step(1);
    push("rst", cyc, 0, 1'b0, 1'b0);
    step(1);
    nRst = 1'b1;
    push("idle0", cyc + 3, 0, 1'b0, 1'b0);
    step(4);

    // 0 -> 37, then 38 arrives at E3 and is picked up after the first result
    base = cyc;
    dispScore = 7'd37;
    push("pre37", base + 8, 0, 1'b0, 1'b0);
    push("s37", base + 9, 37, 1'b0, 1'b0);
    push("hold37", base + 17, 37, 1'b0, 1'b0);
    push("s38", base + 18, 38, 1'b0, 1'b0);
    step(3);
    dispScore = 7'd38;
    step(16);
    cur = 38;

    // Leading-zero suppression and the 99/100/127 dash boundaries
    foreach (vals[i]) begin
      base = cyc;
      dispScore = 7'(vals[i]);
      push("old", base + 8, cur, 1'b0, 1'b0);
      push("new", base + 9, vals[i], 1'b0, 1'b0);
      step(10);
      cur = vals[i];
    end

    // Game end: 12 shown, high score 20 arrives on the same edge
    base = cyc;
    dispScore = 7'd12;
    push("s12", base + 9, 12, 1'b0, 1'b0);
    step(10);
    base = cyc;
    dispScore = 7'd20;
    isGameComplete = 1'b1;
    push("preflash", base, 12, 1'b0, 1'b0);
    for (int k = 1; k <= 2 * int'(FP) * int'(FH); k++) begin
      push("flash", base + k, 12, 1'b1, ((k - 1) / int'(FH)) % 2 == 0);
    end
    for (int k = 2 * int'(FP) * int'(FH) + 1; k <= 2 * int'(FP) * int'(FH) + 9; k++) begin
      push("postflash", base + k, 12, 1'b0, 1'b0);
    end
    push("hs20", base + 2 * int'(FP) * int'(FH) + 10, 20, 1'b0, 1'b0);
    step(2 * int'(FP) * int'(FH) + 12);
    isGameComplete = 1'b0;
    step(2);

    // Flash aborted by a new game
    base = cyc;
    isGameComplete = 1'b1;
    push("ab_blank", base + 1, 20, 1'b1, 1'b1);
    push("ab_blank", base + 2, 20, 1'b1, 1'b1);
    push("ab_blank", base + 3, 20, 1'b1, 1'b1);
    push("ab_exit", base + 4, 20, 1'b0, 1'b0);
    push("ab_after", base + 6, 20, 1'b0, 1'b0);
    step(3);
    isGameComplete = 1'b0;
    step(5);

    // Reset in the middle of a conversion
    base = cyc;
    dispScore = 7'd55;
    push("midconv", base + 3, 20, 1'b0, 1'b0);
    step(4);
    nRst = 1'b0;
    push("rst_mid", base + 4, 0, 1'b0, 1'b0);
    push("rst_hold", base + 5, 0, 1'b0, 1'b0);
    step(2);
    push("rst_rel", base + 6, 0, 1'b0, 1'b0);
    nRst = 1'b1;
    push("pre55", base + 14, 0, 1'b0, 1'b0);
    push("s55", base + 15, 55, 1'b0, 1'b0);
    step(12);

    for (int i = 0; i < 50 && sb.size() > 0; i++) step(1);
    check_eq("drain", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/score_display.md
# score_display

Sequential reader of the score interface. Samples the 7-bit `dispScore` and `isGameComplete` outputs of the score tracker and converts the score to two decimal digits with a multi-cycle shift-add-3 converter. Drives two seven-segment digits. At game end it freezes the final score and flashes it before showing the new value, usually the high score.

## Interface
- `FLASH_HALF`, default 6_000_000: clock cycles per blank/lit half-period (0.5 s at 12 MHz); minimum 1.
- `FLASH_PERIODS`, default 3: number of blank+lit pairs per game-end flash; minimum 1.
- `clk`  in  1  system clock, all state on rising edge.
- `nRst`  in  1  asynchronous, active-low reset.
- `dispScore`  in  7  binary score from tracker, 0–127.
- `isGameComplete`  in  1  level from tracker; high = game over.
- `ss1`  out  7  tens digit segments, active-high, bit0=a … bit6=g.
- `ss0`  out  7  ones digit segments, same encoding.
- `flashing`  out  1  high while the flash sequence runs.

## Operation
- Converter FSM states: IDLE, SHIFT, LOAD.
  - IDLE: if `dispScore != lastScore` and the flash FSM is in NORMAL:
    - capture `dispScore` into the shift register and into `lastScore`;
    - clear the shift count and the BCD accumulators;
    - go to SHIFT.
  - SHIFT: each cycle, add 3 to every BCD nibble that is ≥5, then shift left 1.
    - Stay for exactly 7 cycles.
    - Go to LOAD after the 7th shift.
  - LOAD: copy tens/ones/hundreds into the display digit registers, then return to IDLE.
- Input changes during SHIFT/LOAD are ignored. IDLE re-compares afterwards, so the display always converges to the settled input.
- Display decode (combinational from the digit registers and `blank`):
  - value 100–127: both digits show dash (g only, 7'b1000000);
  - tens digit 0: blanked (leading-zero suppression);
  - `blank`=1: both outputs 0.
- Flash FSM states: NORMAL, FLASH.
  - `gcPrev` is a registered copy of `isGameComplete`.
  - NORMAL→FLASH when `isGameComplete & ~gcPrev`. On entry: clear the half counter and period count, set `blank`=1.
  - In FLASH, at half counter = FLASH_HALF−1: clear the counter and toggle `blank`.
  - On a blank 0→1 toggle, increment the period count.
  - The transition that ends the last lit half (period count reaches FLASH_PERIODS) goes to NORMAL with `blank`=0.
  - FLASH→NORMAL immediately, `blank`=0, if `isGameComplete` is sampled low (new game started).
- Freeze: no new conversion starts while in FLASH. A conversion already in SHIFT/LOAD completes; it converts the pre-flash score.
- `flashing` = (state == FLASH).
- Reset mid-operation: all state returns to reset values on the same `nRst` assertion. Any conversion or flash in progress is abandoned.

## Timing
- Reset values:
  - `lastScore`=0, digits=0, converter IDLE, flash NORMAL, `blank`=0, `gcPrev`=0;
  - outputs: `ss1`=0, `ss0`=7'b0111111 ("0"), `flashing`=0.
- Conversion latency: the edge that samples a new value in IDLE is E0. SHIFT occupies E1–E7 and LOAD is E8. New segments are valid after E8, 8 cycles. The next change can be accepted at E9.
- Flash: `flashing` rises on the edge after the first cycle `isGameComplete`=1 is sampled.
  - Total flash duration is 2·FLASH_PERIODS·FLASH_HALF cycles.
  - The blanked half comes first.
- After flash exit, a pending change (e.g. high score) starts converting in IDLE at the next edge and shows 8 cycles later.
- Simultaneous flash entry and converter IDLE with a changed input: the freeze wins and no conversion starts.

## Structure
- Package `score_disp_pkg`:
  - converter and flash state enums;
  - segment constants for digits 0–9, dash and blank;
  - a `seg_decode` function from a 4-bit value to 7 segments.
- Sub-module `bin2bcd_seq`:
  - ports: `clk`, `nRst`, `start`, `bin[6:0]`, `busy`, `done`, `hundreds`, `tens`, `ones`;
  - holds the IDLE/SHIFT/LOAD FSM.
- The top holds `lastScore`, the flash FSM, the counters (`$clog2` widths) and the decode.

## Test plan
All scenarios use FLASH_HALF=4, FLASH_PERIODS=2.
- Reset, `dispScore`=0 → `ss1`=0, `ss0`=7'b0111111, `flashing`=0.
- `dispScore` 0→37 at E0 → `ss1`=7'b1001111 ("3"), `ss0`=7'b0000111 ("7") after E8, unchanged before.
- `dispScore` 37→38 at E3 of a conversion, then held → first result 37; second conversion starts at the next IDLE; "38" shows 8 cycles later.
- `dispScore`=9 → `ss1`=0; `dispScore`=105 → both digits 7'b1000000.
- Score 12 displayed, then `dispScore`=20 (high score) with `isGameComplete`=1 on the same edge:
  - `flashing`=1 for 16 cycles;
  - pattern is 4 blank / 4 "12" / 4 blank / 4 "12";
  - then "20" after 8 more cycles.
- `isGameComplete` drops mid-flash, or `nRst` asserted mid-conversion:
  - flash aborts with `blank`=0 the next edge;
  - reset values appear immediately on reset.
